// File: rtl/v_vram.sv
// Vector-data RAM responder: self-clearing word memory with masked writes,
// write-first read forwarding and a saturating out-of-range request counter.
module v_vram #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 256,
  parameter int DEPTH  = 1024,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vram_r_ena,
  input  logic [ADDR_W-1:0] vram_r_addr,
  output logic [DATA_W-1:0] vram_r_data,
  input  logic              vram_w_ena,
  input  logic [ADDR_W-1:0] vram_w_addr,
  input  logic [DATA_W-1:0] vram_w_data,
  input  logic [DATA_W-1:0] vram_w_mask,
  output logic              vram_ready,
  output logic [CNT_W-1:0]  oor_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST    = IDX_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              r_in, w_in, r_oor, w_oor, w_hit;
  logic [IDX_W-1:0]  r_idx, w_idx;
  logic [DATA_W-1:0] w_word, r_word;
  logic [1:0]        oor_inc;
  logic [CNT_W:0]    oor_sum;

  assign r_in  = vram_r_addr < DEPTH_A;
  assign w_in  = vram_w_addr < DEPTH_A;
  assign r_idx = vram_r_addr[IDX_W-1:0];
  assign w_idx = vram_w_addr[IDX_W-1:0];
  assign r_oor = vram_r_ena & ~r_in;
  assign w_oor = vram_w_ena & ~w_in;
  assign w_hit = vram_w_ena & w_in & (w_idx == r_idx);

  assign w_word = (mem[w_idx] & ~vram_w_mask) | (vram_w_data & vram_w_mask);
  // Same-address write in the same cycle wins: the read sees the merged word.
  assign r_word = w_hit ? w_word : mem[r_idx];

  assign oor_inc = {1'b0, r_oor} + {1'b0, w_oor};
  assign oor_sum = {1'b0, oor_cnt} + (CNT_W + 1)'(oor_inc);

  // Storage has no reset; the clear sweep in INIT defines its contents.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clr_ptr] <= '0;
    end else if (vram_w_ena && w_in) begin
      mem[w_idx] <= w_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= INIT;
      clr_ptr     <= '0;
      vram_ready  <= 1'b0;
      vram_r_data <= '0;
      oor_cnt     <= '0;
    end else begin
      case (state)
        INIT: begin
          clr_ptr <= clr_ptr + IDX_W'(1);
          if (clr_ptr == LAST) begin
            state      <= RUN;
            vram_ready <= 1'b1;
          end
        end
        RUN: begin
          if (vram_r_ena) begin
            vram_r_data <= r_in ? r_word : '0;
          end
          oor_cnt <= oor_sum[CNT_W] ? '1 : oor_sum[CNT_W-1:0];
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_v_vram.sv
// Directed bench for v_vram: a reference memory model feeds an expected-read
// queue that is popped and compared when the registered read data appears.
module tb_v_vram;

  localparam int AW = 64;
  localparam int DW = 256;
  localparam int DP = 16;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          vram_r_ena;
  logic [AW-1:0] vram_r_addr;
  logic [DW-1:0] vram_r_data;
  logic          vram_w_ena;
  logic [AW-1:0] vram_w_addr;
  logic [DW-1:0] vram_w_data;
  logic [DW-1:0] vram_w_mask;
  logic          vram_ready;
  logic [CW-1:0] oor_cnt;

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] model [DP];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_rd;
  logic [CW-1:0] exp_oor;

  v_vram #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .vram_r_ena(vram_r_ena), .vram_r_addr(vram_r_addr), .vram_r_data(vram_r_data),
    .vram_w_ena(vram_w_ena), .vram_w_addr(vram_w_addr), .vram_w_data(vram_w_data),
    .vram_w_mask(vram_w_mask), .vram_ready(vram_ready), .oor_cnt(oor_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    check({tag, ".data"}, vram_r_data, exp_rd);
    check({tag, ".oor"}, DW'(oor_cnt), DW'(exp_oor));
    check({tag, ".ready"}, DW'(vram_ready), DW'(1));
  endtask

  task automatic idle_inputs();
    vram_r_ena  = 1'b0;
    vram_r_addr = '0;
    vram_w_ena  = 1'b0;
    vram_w_addr = '0;
    vram_w_data = '0;
    vram_w_mask = '0;
  endtask

  // One RUN-mode cycle: drive, predict against the model, then compare after the edge.
  task automatic apply_stimulus(input logic re, input logic [AW-1:0] ra, input logic we,
                                input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic [DW-1:0] wm, input string tag);
    logic [DW-1:0] merged;
    int            inc;
    @(negedge clk);
    vram_r_ena  = re;
    vram_r_addr = ra;
    vram_w_ena  = we;
    vram_w_addr = wa;
    vram_w_data = wd;
    vram_w_mask = wm;
    merged = '0;
    if (we && wa < DP) merged = (model[wa[3:0]] & ~wm) | (wd & wm);
    if (re) begin
      if (ra >= DP) exp_q.push_back('0);
      else if (we && wa == ra) exp_q.push_back(merged);
      else exp_q.push_back(model[ra[3:0]]);
    end
    if (we && wa < DP) model[wa[3:0]] = merged;
    inc = int'(re && ra >= DP) + int'(we && wa >= DP);
    exp_oor = (int'(exp_oor) + inc > 3) ? CW'(3) : CW'(int'(exp_oor) + inc);
    @(posedge clk);
    #1;
    if (re) exp_rd = exp_q.pop_front();
    check_output(tag);
  endtask

  // Release reset and hammer requests during the clear sweep; they must be ignored.
  task automatic wait_clear(input string tag);
    int  n = 0;
    bit  seen = 0;
    @(negedge clk);
    rst         = 1'b1;
    vram_r_ena  = 1'b1;
    vram_r_addr = 64'd0;
    vram_w_ena  = 1'b1;
    vram_w_data = '1;
    vram_w_mask = '1;
    for (int i = 0; i < 40 && !seen; i++) begin
      vram_w_addr = (i % 2 == 1) ? 64'd0 : 64'd20;
      vram_r_addr = (i % 3 == 2) ? 64'd21 : 64'd0;
      @(posedge clk);
      #1;
      n++;
      if (vram_ready) seen = 1;
      else begin
        check({tag, ".init_data"}, vram_r_data, '0);
        check({tag, ".init_oor"}, DW'(oor_cnt), '0);
      end
    end
    idle_inputs();
    check({tag, ".ready_cycles"}, DW'(n), DW'(DP));
    check({tag, ".ready_data"}, vram_r_data, '0);
    check({tag, ".ready_oor"}, DW'(oor_cnt), '0);
    for (int a = 0; a < DP; a++) model[a] = '0;
    exp_rd  = '0;
    exp_oor = '0;
  endtask

  task automatic sweep_zero(input string tag);
    for (int a = 0; a < DP; a++) apply_stimulus(1'b1, AW'(a), 1'b0, '0, '0, '0, tag);
  endtask

  task automatic check_reset_now(input string tag);
    check({tag, ".data"}, vram_r_data, '0);
    check({tag, ".ready"}, DW'(vram_ready), '0);
    check({tag, ".oor"}, DW'(oor_cnt), '0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DW-1:0] a5, ones, m00ff;
    a5    = {32{8'hA5}};
    ones  = '1;
    m00ff = {16{16'h00FF}};
    rst   = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_now("reset");

    wait_clear("clear1");
    sweep_zero("zero1");

    apply_stimulus(1'b0, '0, 1'b1, 64'd3, a5, ones, "wr3");
    apply_stimulus(1'b1, 64'd3, 1'b0, '0, '0, '0, "rd3");
    apply_stimulus(1'b0, 64'd3, 1'b0, '0, '0, '0, "hold1");
    apply_stimulus(1'b0, 64'd9, 1'b1, 64'd4, ones, ones, "hold2");
    apply_stimulus(1'b0, '0, 1'b1, 64'd3, ones, m00ff, "mask_wr3");
    apply_stimulus(1'b1, 64'd3, 1'b0, '0, '0, '0, "mask_rd3");
    check("mask_const", vram_r_data, {16{16'hA5FF}});
    apply_stimulus(1'b0, '0, 1'b1, 64'd3, ones, '0, "zero_mask_wr3");
    apply_stimulus(1'b1, 64'd3, 1'b0, '0, '0, '0, "zero_mask_rd3");
    apply_stimulus(1'b1, 64'd5, 1'b1, 64'd5, DW'(16'h1234), ones, "fwd5");
    check("fwd_const", vram_r_data, DW'(16'h1234));
    apply_stimulus(1'b0, '0, 1'b1, 64'd6, DW'(16'h6666), ones, "wr6");
    apply_stimulus(1'b1, 64'd6, 1'b1, 64'd7, DW'(16'h7777), ones, "rd6_wr7");
    apply_stimulus(1'b1, 64'd7, 1'b0, '0, '0, '0, "rd7");
    apply_stimulus(1'b1, 64'd4, 1'b0, '0, '0, '0, "rd4");
    apply_stimulus(1'b1, 64'd16, 1'b1, 64'd16, ones, ones, "oor1");
    apply_stimulus(1'b1, 64'd0, 1'b0, '0, '0, '0, "alias0_a");
    apply_stimulus(1'b1, 64'd16, 1'b1, 64'd16, ones, ones, "oor_sat");
    apply_stimulus(1'b0, '0, 1'b1, 64'h1_0000_0003, ones, ones, "oor_hi_wr");
    apply_stimulus(1'b1, 64'd3, 1'b0, '0, '0, '0, "rd3_after_oor");
    apply_stimulus(1'b1, 64'd0, 1'b0, '0, '0, '0, "alias0_b");

    // Asynchronous reset while serving, away from any clock edge.
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_now("rst_run");
    @(posedge clk);
    wait_clear("clear2");

    // Abort the sweep after word 6 is cleared (clr_ptr == 7), then restart it.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_now("rst_mid");
    @(posedge clk);
    wait_clear("clear3");
    sweep_zero("zero3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
